// File: rtl/mem_lsu.sv
// mem_lsu: load/store unit between the datapath and a data memory port.
//
// A request is checked for range and alignment faults in the cycle it is
// presented. A clean request is forwarded to memory in that cycle and its
// lane information is queued in a small in-order FIFO. Responses come back
// in order. Each response pops the FIFO head, which is used to align and
// extend the load data with no added latency. A fault latches its code and
// the block holds in S_EXC_HOLD until a flush. A flush discards the in-flight
// responses by draining them in S_DRAIN.
//
// Ports:
//   clk, resetn              clock, asynchronous active-low reset
//   req_*                    datapath request (valid/ready handshake)
//   resp_valid_o/rd_data_o   load/store completion back to the datapath
//   dmem_req_o .. mask_o     memory request (combinational, one-cycle pulse)
//   dmem_resp_*              memory response (always accepted)
//   flush_i                  pipeline flush
//   exc_valid_i/exc_code_i   upstream exception
//   exc_valid_o/exc_code_o   exception to the pipeline
module mem_lsu #(
    parameter int          DATA_W          = 64,
    parameter logic [63:0] MEM_BASE        = 64'h0000_0000_0001_0000,
    parameter logic [63:0] MEM_LIMIT       = 64'h0000_0000_0001_BFFF,
    parameter int          MAX_OUTSTANDING = 4
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                req_valid_i,
    input  logic [DATA_W-1:0]   req_addr_i,
    input  logic [1:0]          req_size_i,
    input  logic                req_wr_i,
    input  logic                req_zero_extnd_i,
    input  logic [DATA_W-1:0]   req_wr_data_i,
    output logic                req_ready_o,
    output logic                resp_valid_o,
    output logic [DATA_W-1:0]   resp_rd_data_o,
    output logic                dmem_req_o,
    input  logic                dmem_ready_i,
    output logic [DATA_W-1:0]   dmem_addr_o,
    output logic                dmem_wr_o,
    output logic [DATA_W-1:0]   dmem_wr_data_o,
    output logic [DATA_W/8-1:0] dmem_mask_o,
    input  logic                dmem_resp_valid_i,
    input  logic [DATA_W-1:0]   dmem_resp_data_i,
    output logic                dmem_resp_ready_o,
    input  logic                flush_i,
    input  logic                exc_valid_i,
    input  logic [4:0]          exc_code_i,
    output logic                exc_valid_o,
    output logic [4:0]          exc_code_o
);

    localparam int BW    = DATA_W / 8;
    localparam int OFF_W = $clog2(BW);
    localparam int IDX_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int PTR_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam int ENT_W = OFF_W + 4;

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_EXC_HOLD = 2'd1,
        S_DRAIN    = 2'd2
    } state_t;

    state_t                 state_r, state_nxt_s;
    logic [PTR_W-1:0]       drain_cnt_r, drain_cnt_nxt_s;
    logic [4:0]             exc_code_r, exc_code_nxt_s;
    logic [PTR_W-1:0]       wr_ptr_r, rd_ptr_r;
    logic [ENT_W-1:0]       fifo_mem_r [MAX_OUTSTANDING];

    logic                   fifo_empty_s, fifo_full_s;
    logic [PTR_W-1:0]       fifo_cnt_s, flush_cnt_s;
    logic                   ready_s, qual_s, oob_s, mis_s, fault_s;
    logic                   push_s, pop_s;
    logic [4:0]             run_code_s;
    logic [ENT_W-1:0]       push_ent_s, head_ent_s;
    logic [DATA_W-1:0]      load_data_s;

    // FIFO slot index; with a single slot only the wrap bit toggles.
    function automatic logic [IDX_W-1:0] idx_f(input logic [PTR_W-1:0] p);
        if (MAX_OUTSTANDING == 1) begin
            idx_f = {IDX_W{1'b0}};
        end else begin
            idx_f = p[IDX_W-1:0];
        end
    endfunction

    function automatic logic misalign_f(input logic [2:0] lo, input logic [1:0] size);
        case (size)
            2'd0:    misalign_f = 1'b0;
            2'd1:    misalign_f = lo[0];
            2'd2:    misalign_f = (lo[1:0] != 2'd0);
            2'd3:    misalign_f = (DATA_W == 32) ? 1'b1 : (lo != 3'd0);
            default: misalign_f = 1'b1;
        endcase
    endfunction

    function automatic logic [BW-1:0] mask_f(input logic [OFF_W-1:0] off, input logic [1:0] size);
        logic [BW-1:0] m;
        case (size)
            2'd0:    m = BW'(4'h1);
            2'd1:    m = BW'(4'h3);
            2'd2:    m = BW'(4'hF);
            2'd3:    m = {BW{1'b1}};
            default: m = {BW{1'b0}};
        endcase
        mask_f = m << off;
    endfunction

    // Store data is replicated across all lanes of its size, so the lane
    // selected by the byte mask always carries it without a shift.
    function automatic logic [DATA_W-1:0] repl_f(input logic [DATA_W-1:0] d, input logic [1:0] size);
        case (size)
            2'd0:    repl_f = {BW{d[7:0]}};
            2'd1:    repl_f = {(BW/2){d[15:0]}};
            2'd2:    repl_f = {(BW/4){d[31:0]}};
            2'd3:    repl_f = d;
            default: repl_f = {DATA_W{1'b0}};
        endcase
    endfunction

    // Extract the sized field at the byte offset and extend it. The field
    // mask avoids zero-width replications when DATA_W is 32.
    function automatic logic [DATA_W-1:0] extract_f(input logic [DATA_W-1:0] d,
                                                    input logic [OFF_W-1:0] off,
                                                    input logic [1:0] size,
                                                    input logic zext);
        logic [DATA_W-1:0] sh, fm;
        logic              sgn;
        sh = d >> {off, 3'b000};
        case (size)
            2'd0: begin fm = DATA_W'(8'hFF);          sgn = sh[7];  end
            2'd1: begin fm = DATA_W'(16'hFFFF);       sgn = sh[15]; end
            2'd2: begin fm = DATA_W'(32'hFFFF_FFFF);  sgn = sh[31]; end
            2'd3: begin fm = {DATA_W{1'b1}};          sgn = 1'b0;   end
            default: begin fm = {DATA_W{1'b0}};       sgn = 1'b0;   end
        endcase
        extract_f = (sh & fm) | ({DATA_W{sgn & ~zext}} & ~fm);
    endfunction

    // FIFO status and request qualification.
    always_comb begin
        fifo_empty_s = (wr_ptr_r == rd_ptr_r);
        fifo_full_s  = (wr_ptr_r[PTR_W-1] != rd_ptr_r[PTR_W-1]) &&
                       (idx_f(wr_ptr_r) == idx_f(rd_ptr_r));
        fifo_cnt_s   = wr_ptr_r - rd_ptr_r;
        ready_s      = resetn & (state_r == S_RUN) & dmem_ready_i & ~fifo_full_s;
        qual_s       = req_valid_i & ready_s & ~flush_i;
        oob_s        = qual_s & ((req_addr_i < DATA_W'(MEM_BASE)) ||
                                 (req_addr_i > DATA_W'(MEM_LIMIT)));
        mis_s        = qual_s & misalign_f(req_addr_i[2:0], req_size_i);
        fault_s      = resetn & (exc_valid_i | oob_s | mis_s);
        push_s       = qual_s & ~fault_s;
        pop_s        = resetn & dmem_resp_valid_i & ~fifo_empty_s;
        flush_cnt_s  = fifo_cnt_s - PTR_W'(pop_s);
        if (exc_valid_i) begin
            run_code_s = exc_code_i;
        end else if (oob_s) begin
            run_code_s = req_wr_i ? 5'd7 : 5'd5;
        end else if (mis_s) begin
            run_code_s = req_wr_i ? 5'd6 : 5'd4;
        end else begin
            run_code_s = 5'd0;
        end
        push_ent_s   = {req_addr_i[OFF_W-1:0], req_size_i, req_zero_extnd_i, req_wr_i};
        head_ent_s   = fifo_mem_r[idx_f(rd_ptr_r)];
        load_data_s  = extract_f(dmem_resp_data_i, head_ent_s[ENT_W-1:4],
                                 head_ent_s[3:2], head_ent_s[1]);
    end

    // Datapath-facing and memory-facing outputs.
    always_comb begin
        req_ready_o       = ready_s;
        dmem_resp_ready_o = 1'b1;
        dmem_req_o        = push_s;
        dmem_addr_o       = push_s ? req_addr_i : {DATA_W{1'b0}};
        dmem_wr_o         = push_s & req_wr_i;
        if (push_s && req_wr_i) begin
            dmem_wr_data_o = repl_f(req_wr_data_i, req_size_i);
            dmem_mask_o    = mask_f(req_addr_i[OFF_W-1:0], req_size_i);
        end else begin
            dmem_wr_data_o = {DATA_W{1'b0}};
            dmem_mask_o    = {BW{1'b0}};
        end
        resp_valid_o = pop_s & (state_r == S_RUN) & ~flush_i;
        if (resp_valid_o && !head_ent_s[0]) begin
            resp_rd_data_o = load_data_s;
        end else begin
            resp_rd_data_o = {DATA_W{1'b0}};
        end
        case (state_r)
            S_RUN: begin
                exc_valid_o = fault_s;
                exc_code_o  = fault_s ? run_code_s : 5'd0;
            end
            S_EXC_HOLD: begin
                exc_valid_o = resetn;
                exc_code_o  = resetn ? exc_code_r : 5'd0;
            end
            default: begin
                exc_valid_o = 1'b0;
                exc_code_o  = 5'd0;
            end
        endcase
    end

    // Next-state, drain counter and latched exception code.
    always_comb begin
        state_nxt_s     = state_r;
        drain_cnt_nxt_s = drain_cnt_r;
        exc_code_nxt_s  = exc_code_r;
        case (state_r)
            S_RUN: begin
                if (flush_i) begin
                    drain_cnt_nxt_s = flush_cnt_s;
                    state_nxt_s     = (flush_cnt_s != {PTR_W{1'b0}}) ? S_DRAIN : S_RUN;
                end else if (fault_s) begin
                    exc_code_nxt_s  = run_code_s;
                    state_nxt_s     = S_EXC_HOLD;
                end else begin
                    state_nxt_s     = S_RUN;
                end
            end
            S_EXC_HOLD: begin
                if (flush_i) begin
                    drain_cnt_nxt_s = flush_cnt_s;
                    state_nxt_s     = (flush_cnt_s != {PTR_W{1'b0}}) ? S_DRAIN : S_RUN;
                end else begin
                    state_nxt_s     = S_EXC_HOLD;
                end
            end
            S_DRAIN: begin
                if (flush_i) begin
                    drain_cnt_nxt_s = flush_cnt_s;
                    state_nxt_s     = (flush_cnt_s != {PTR_W{1'b0}}) ? S_DRAIN : S_RUN;
                end else if (pop_s) begin
                    drain_cnt_nxt_s = drain_cnt_r - PTR_W'(1'b1);
                    state_nxt_s     = (drain_cnt_r <= PTR_W'(1'b1)) ? S_RUN : S_DRAIN;
                end else begin
                    state_nxt_s     = S_DRAIN;
                end
            end
            default: begin
                state_nxt_s     = S_RUN;
                drain_cnt_nxt_s = {PTR_W{1'b0}};
            end
        endcase
    end

    // State, drain counter and exception code registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r     <= S_RUN;
            drain_cnt_r <= {PTR_W{1'b0}};
            exc_code_r  <= 5'd0;
        end else begin
            state_r     <= state_nxt_s;
            drain_cnt_r <= drain_cnt_nxt_s;
            exc_code_r  <= exc_code_nxt_s;
        end
    end

    // Pending-request FIFO storage and pointers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                fifo_mem_r[i] <= {ENT_W{1'b0}};
            end
        end else begin
            if (push_s) begin
                fifo_mem_r[idx_f(wr_ptr_r)] <= push_ent_s;
                wr_ptr_r                    <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
        end
    end

endmodule
